// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Bundle of the register-file access signals shared between the
//            decode/writeback pipeline (master) and the register file (slave).
// Signals  : write_enable/write_addr/write_data  - writeback ports (packed)
//            read_enable/read_addr                - operand read requests
//            read_data/read_busy                  - operand read results
//            reserve_enable/reserve_addr          - destination reservation
//            flush                                - clear all reservations
//            busy_count                           - registered busy popcount
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_mp_if #(
    parameter int XLEN            = 32,
    parameter int ADDR_SIZE       = 5,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 1
);
    logic [NUM_WRITE_PORTS-1:0]           write_enable;
    logic [NUM_WRITE_PORTS*ADDR_SIZE-1:0] write_addr;
    logic [NUM_WRITE_PORTS*XLEN-1:0]      write_data;
    logic [NUM_READ_PORTS-1:0]            read_enable;
    logic [NUM_READ_PORTS*ADDR_SIZE-1:0]  read_addr;
    logic [NUM_READ_PORTS*XLEN-1:0]       read_data;
    logic [NUM_READ_PORTS-1:0]            read_busy;
    logic                                 reserve_enable;
    logic [ADDR_SIZE-1:0]                 reserve_addr;
    logic                                 flush;
    logic [ADDR_SIZE:0]                   busy_count;

    modport master (
        output write_enable, write_addr, write_data,
        output read_enable, read_addr,
        input  read_data, read_busy,
        output reserve_enable, reserve_addr, flush,
        input  busy_count
    );

    modport slave (
        input  write_enable, write_addr, write_data,
        input  read_enable, read_addr,
        output read_data, read_busy,
        input  reserve_enable, reserve_addr, flush,
        output busy_count
    );
endinterface
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port integer register file with per-register busy
//            scoreboard and optional same-cycle write-to-read bypass.
//            x0 is hardwired to zero and never busy.
// Ports    : clk  - rising-edge clock
//            rst  - asynchronous active-high reset
//            bus  - regfile_mp_if.slave (write, read, reserve, flush, count)
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
    parameter int XLEN            = 32,
    parameter int ADDR_SIZE       = 5,
    parameter int NUM_READ_PORTS  = 2,
    parameter int NUM_WRITE_PORTS = 1,
    parameter int BYPASS          = 1
) (
    input  wire logic      clk,
    input  wire logic      rst,
    regfile_mp_if.slave    bus
);

    localparam int NUM_REGISTERS = 2**ADDR_SIZE;

    // ------------------------------------------------------------------
    // Unpacked views of the packed port buses
    // ------------------------------------------------------------------
    logic                 w_wr_en   [NUM_WRITE_PORTS];
    logic [ADDR_SIZE-1:0] w_wr_addr [NUM_WRITE_PORTS];
    logic [XLEN-1:0]      w_wr_data [NUM_WRITE_PORTS];

    always_comb begin
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            // A write to x0 is dropped here so nothing downstream sees it
            w_wr_addr[p] = bus.write_addr[p*ADDR_SIZE +: ADDR_SIZE];
            w_wr_data[p] = bus.write_data[p*XLEN +: XLEN];
            w_wr_en[p]   = bus.write_enable[p] && (w_wr_addr[p] != '0);
        end
    end

    // ------------------------------------------------------------------
    // Register storage (entry 0 is a constant, not a flop)
    // ------------------------------------------------------------------
    logic [XLEN-1:0] w_regs [NUM_REGISTERS];

    assign w_regs[0] = '0;

    generate
        for (genvar gi = 1; gi < NUM_REGISTERS; gi++) begin : g_reg
            logic            w_we;
            logic [XLEN-1:0] w_wd;
            logic [XLEN-1:0] r_q;

            // Ascending scan: the highest-index port hitting this register wins
            always_comb begin
                w_we = 1'b0;
                w_wd = '0;
                for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                    if (w_wr_en[p] && (w_wr_addr[p] == ADDR_SIZE'(gi))) begin
                        w_we = 1'b1;
                        w_wd = w_wr_data[p];
                    end
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_q <= '0;
                end else if (w_we) begin
                    r_q <= w_wd;
                end
            end

            assign w_regs[gi] = r_q;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Busy scoreboard: writes clear, reserve sets (reserve beats a write
    // to the same register), flush clears everything and beats reserve.
    // ------------------------------------------------------------------
    logic [NUM_REGISTERS-1:0] r_busy;
    logic [NUM_REGISTERS-1:0] w_busy_nxt;
    logic [ADDR_SIZE:0]       w_count_nxt;
    logic [ADDR_SIZE:0]       r_busy_count;

    always_comb begin
        w_busy_nxt = r_busy;
        for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
            if (w_wr_en[p]) begin
                w_busy_nxt[w_wr_addr[p]] = 1'b0;
            end
        end
        if (bus.reserve_enable && (bus.reserve_addr != '0)) begin
            w_busy_nxt[bus.reserve_addr] = 1'b1;
        end
        if (bus.flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Count is registered alongside the busy vector so it always matches
    // the state produced by the most recent edge.
    always_comb begin
        w_count_nxt = '0;
        for (int i = 1; i < NUM_REGISTERS; i++) begin
            w_count_nxt = w_count_nxt + (ADDR_SIZE+1)'(w_busy_nxt[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy       <= '0;
            r_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            r_busy_count <= w_count_nxt;
        end
    end

    assign bus.busy_count = r_busy_count;

    // ------------------------------------------------------------------
    // Read ports (combinational)
    // ------------------------------------------------------------------
    logic [NUM_READ_PORTS*XLEN-1:0] w_read_data;
    logic [NUM_READ_PORTS-1:0]      w_read_busy;
    logic [ADDR_SIZE-1:0]           w_rd_addr;

    always_comb begin
        w_read_data = '0;
        w_read_busy = '0;
        w_rd_addr   = '0;
        for (int r = 0; r < NUM_READ_PORTS; r++) begin
            w_rd_addr = bus.read_addr[r*ADDR_SIZE +: ADDR_SIZE];
            // rst gates the read path so bypassed write data cannot leak
            // out while the file is held in reset.
            if (!rst && bus.read_enable[r] && (w_rd_addr != '0)) begin
                w_read_data[r*XLEN +: XLEN] = w_regs[w_rd_addr];
                w_read_busy[r]              = r_busy[w_rd_addr];
                if (BYPASS != 0) begin
                    for (int p = 0; p < NUM_WRITE_PORTS; p++) begin
                        if (w_wr_en[p] && (w_wr_addr[p] == w_rd_addr)) begin
                            w_read_data[r*XLEN +: XLEN] = w_wr_data[p];
                            w_read_busy[r]              = 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign bus.read_data = w_read_data;
    assign bus.read_busy = w_read_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp. Main instance has two write
//            ports with bypass; a second single-write-port instance has
//            bypass disabled.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

    logic clk;
    logic rst;

    regfile_mp_if #(.XLEN(32), .ADDR_SIZE(5), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2)) rf ();
    regfile_mp_if #(.XLEN(32), .ADDR_SIZE(5), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(1)) rf0 ();

    regfile_mp #(.XLEN(32), .ADDR_SIZE(5), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(2), .BYPASS(1)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (rf)
    );

    regfile_mp #(.XLEN(32), .ADDR_SIZE(5), .NUM_READ_PORTS(2), .NUM_WRITE_PORTS(1), .BYPASS(0)) u_dut_nobyp (
        .clk (clk),
        .rst (rst),
        .bus (rf0)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] exp_q [$];
    logic [63:0] e;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.write_enable   = '0; rf.write_addr = '0; rf.write_data = '0;
        rf.read_enable    = '0; rf.read_addr  = '0;
        rf.reserve_enable = 1'b0; rf.reserve_addr = '0; rf.flush = 1'b0;
        rf0.write_enable  = '0; rf0.write_addr = '0; rf0.write_data = '0;
        rf0.read_enable   = '0; rf0.read_addr  = '0;
        rf0.reserve_enable = 1'b0; rf0.reserve_addr = '0; rf0.flush = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'd5}; rf.write_data = {32'h0, 32'hDEADBEEF};
        rf.read_enable  = 2'b11; rf.read_addr  = {5'd5, 5'd5};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        step(); step();
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL reset_read_data actual=%h required=%h", rf.read_data, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL reset_read_busy actual=%h required=%h", rf.read_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL reset_busy_count actual=%h required=%h", rf.busy_count, e); end
        step();
        idle();
        rst = 1'b0;
        step();
        rf.read_enable = 2'b01; rf.read_addr = {5'd0, 5'd5};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[31:0]) !== e) begin failures++; $display("FAIL post_reset_x5 actual=%h required=%h", rf.read_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL post_reset_count actual=%h required=%h", rf.busy_count, e); end
    endtask

    task automatic test_write_bypass();
        step(); idle();
        rf.write_enable  = 2'b01; rf.write_addr  = {5'd0, 5'd3}; rf.write_data = {32'h0, 32'h12345678};
        rf.read_enable   = 2'b01; rf.read_addr   = {5'd0, 5'd3};
        rf0.write_enable = 1'b1;  rf0.write_addr = 5'd3;         rf0.write_data = 32'h12345678;
        rf0.read_enable  = 2'b01; rf0.read_addr  = {5'd0, 5'd3};
        exp_q.push_back(64'h12345678); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[31:0]) !== e) begin failures++; $display("FAIL bypass_same_cycle actual=%h required=%h", rf.read_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf0.read_data[31:0]) !== e) begin failures++; $display("FAIL nobypass_same_cycle actual=%h required=%h", rf0.read_data[31:0], e); end
        step();
        rf.write_enable = '0; rf0.write_enable = '0;
        exp_q.push_back(64'h12345678); exp_q.push_back(64'h12345678);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[31:0]) !== e) begin failures++; $display("FAIL bypass_stored actual=%h required=%h", rf.read_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf0.read_data[31:0]) !== e) begin failures++; $display("FAIL nobypass_next_cycle actual=%h required=%h", rf0.read_data[31:0], e); end
    endtask

    task automatic test_x0();
        step(); idle();
        rf.write_enable   = 2'b01; rf.write_addr = {5'd0, 5'd0}; rf.write_data = {32'h0, 32'hFFFFFFFF};
        rf.reserve_enable = 1'b1;  rf.reserve_addr = 5'd0;
        rf.read_enable    = 2'b11; rf.read_addr  = {5'd0, 5'd0};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL x0_same_cycle actual=%h required=%h", rf.read_data, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL x0_busy_same_cycle actual=%h required=%h", rf.read_busy, e); end
        step();
        rf.write_enable = '0; rf.reserve_enable = 1'b0;
        step();
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL x0_after actual=%h required=%h", rf.read_data, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL x0_busy_after actual=%h required=%h", rf.read_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL x0_count actual=%h required=%h", rf.busy_count, e); end
    endtask

    task automatic test_scoreboard();
        step(); idle();
        // Reserve x7, reading it in the same cycle sees the old (clear) bit
        rf.reserve_enable = 1'b1; rf.reserve_addr = 5'd7;
        rf.read_enable = 2'b10; rf.read_addr = {5'd7, 5'd0};
        exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[1]) !== e) begin failures++; $display("FAIL reserve_same_cycle actual=%h required=%h", rf.read_busy[1], e); end
        step();
        rf.reserve_enable = 1'b0;
        exp_q.push_back(64'h1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[1]) !== e) begin failures++; $display("FAIL reserve_next_cycle actual=%h required=%h", rf.read_busy[1], e); end
        step();
        exp_q.push_back(64'h1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL reserve_count actual=%h required=%h", rf.busy_count, e); end
        step();
        // Write x7 while busy: bypass forwards data and masks busy
        rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'd7}; rf.write_data = {32'h0, 32'hA5};
        exp_q.push_back(64'hA5); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL write_bypass_x7 actual=%h required=%h", rf.read_data[63:32], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[1]) !== e) begin failures++; $display("FAIL write_bypass_busy actual=%h required=%h", rf.read_busy[1], e); end
        step();
        rf.write_enable = '0;
        step();
        exp_q.push_back(64'hA5); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL write_stored_x7 actual=%h required=%h", rf.read_data[63:32], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[1]) !== e) begin failures++; $display("FAIL write_cleared_busy actual=%h required=%h", rf.read_busy[1], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL write_cleared_count actual=%h required=%h", rf.busy_count, e); end
        step();
        // Reserve and write x7 (via port 1) together: reserve wins, data commits
        rf.reserve_enable = 1'b1; rf.reserve_addr = 5'd7;
        rf.write_enable = 2'b10; rf.write_addr = {5'd7, 5'd0}; rf.write_data = {32'hA5, 32'h0};
        step();
        rf.reserve_enable = 1'b0; rf.write_enable = '0;
        exp_q.push_back(64'h1); exp_q.push_back(64'hA5);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[1]) !== e) begin failures++; $display("FAIL reserve_write_busy actual=%h required=%h", rf.read_busy[1], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL reserve_write_data actual=%h required=%h", rf.read_data[63:32], e); end
        step();
        // Release x7 again so later counts start from zero
        rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'd7}; rf.write_data = {32'h0, 32'hA5};
        step();
        rf.write_enable = '0;
        step();
        exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL release_count actual=%h required=%h", rf.busy_count, e); end
    endtask

    task automatic test_dual_write();
        step(); idle();
        rf.write_enable = 2'b11; rf.write_addr = {5'd9, 5'd9}; rf.write_data = {32'h2, 32'h1};
        rf.read_enable  = 2'b01; rf.read_addr  = {5'd9, 5'd9};
        exp_q.push_back(64'h2); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[31:0]) !== e) begin failures++; $display("FAIL dual_bypass actual=%h required=%h", rf.read_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL read_disabled actual=%h required=%h", rf.read_data[63:32], e); end
        step();
        rf.write_enable = 2'b11; rf.write_addr = {5'd11, 5'd10}; rf.write_data = {32'h11, 32'h10};
        rf.read_enable  = 2'b11;
        exp_q.push_back({32'h2, 32'h2});
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL dual_stored actual=%h required=%h", rf.read_data, e); end
        step();
        rf.write_enable = '0; rf.read_addr = {5'd11, 5'd10};
        exp_q.push_back({32'h11, 32'h10});
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL dual_distinct actual=%h required=%h", rf.read_data, e); end
    endtask

    task automatic test_flush();
        logic [4:0] addrs [3] = '{5'd1, 5'd2, 5'd4};
        step(); idle();
        for (int i = 0; i < 3; i++) begin
            rf.reserve_enable = 1'b1; rf.reserve_addr = addrs[i];
            step();
        end
        rf.reserve_enable = 1'b0;
        step();
        rf.read_enable = 2'b11; rf.read_addr = {5'd4, 5'd2};
        exp_q.push_back(64'h3); exp_q.push_back(64'h3);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL flush_pre_count actual=%h required=%h", rf.busy_count, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL flush_pre_busy actual=%h required=%h", rf.read_busy, e); end
        step();
        rf.flush = 1'b1; rf.reserve_enable = 1'b1; rf.reserve_addr = 5'd6;
        rf.write_enable = 2'b10; rf.write_addr = {5'd12, 5'd0}; rf.write_data = {32'hC0, 32'h0};
        step();
        idle();
        rf.read_enable = 2'b11; rf.read_addr = {5'd12, 5'd6};
        exp_q.push_back(64'h0); exp_q.push_back(64'hC0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL flush_busy actual=%h required=%h", rf.read_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL flush_write_commit actual=%h required=%h", rf.read_data[63:32], e); end
        step();
        exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL flush_count actual=%h required=%h", rf.busy_count, e); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        step(); idle();
        for (int i = 0; i < 4; i++) begin
            v = $urandom;
            rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'(20 + i)}; rf.write_data = {32'h0, v};
            rf.read_enable = 2'b01; rf.read_addr = {5'd0, 5'(20 + i)};
            exp_q.push_back(64'(v));
            #2;
            if (64'(rf.read_data[31:0]) !== 64'(v)) begin
                failures++; $display("FAIL b2b_bypass actual=%h required=%h", rf.read_data[31:0], v);
            end
            checks++;
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) begin
            rf.read_enable = 2'b10; rf.read_addr = {5'(20 + i), 5'd0};
            #2;
            e = exp_q.pop_front(); checks++;
            if (64'(rf.read_data[63:32]) !== e) begin failures++; $display("FAIL b2b_readback actual=%h required=%h", rf.read_data[63:32], e); end
            step();
        end
    endtask

    task automatic test_async_reset();
        step(); idle();
        rf.reserve_enable = 1'b1; rf.reserve_addr = 5'd5;
        rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'd5}; rf.write_data = {32'h0, 32'h55};
        step();
        rf.reserve_enable = 1'b0; rf.write_enable = '0;
        step();
        rf.read_enable = 2'b01; rf.read_addr = {5'd0, 5'd5};
        exp_q.push_back(64'h1); exp_q.push_back(64'h55); exp_q.push_back(64'h1);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL arst_pre_count actual=%h required=%h", rf.busy_count, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data[31:0]) !== e) begin failures++; $display("FAIL arst_pre_data actual=%h required=%h", rf.read_data[31:0], e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy[0]) !== e) begin failures++; $display("FAIL arst_pre_busy actual=%h required=%h", rf.read_busy[0], e); end
        // Assert reset between edges with a write in flight
        #2;
        rst = 1'b1;
        rf.write_enable = 2'b01; rf.write_addr = {5'd0, 5'd13}; rf.write_data = {32'h0, 32'h13};
        exp_q.push_back(64'h0); exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #1;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL arst_data actual=%h required=%h", rf.read_data, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL arst_busy actual=%h required=%h", rf.read_busy, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.busy_count) !== e) begin failures++; $display("FAIL arst_count actual=%h required=%h", rf.busy_count, e); end
        step();
        idle();
        rst = 1'b0;
        rf.read_enable = 2'b11; rf.read_addr = {5'd5, 5'd13};
        step();
        exp_q.push_back(64'h0); exp_q.push_back(64'h0);
        #2;
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_data) !== e) begin failures++; $display("FAIL arst_discard actual=%h required=%h", rf.read_data, e); end
        e = exp_q.pop_front(); checks++;
        if (64'(rf.read_busy) !== e) begin failures++; $display("FAIL arst_discard_busy actual=%h required=%h", rf.read_busy, e); end
    endtask

    initial begin
        rst = 1'b1;
        idle();
        test_reset();
        test_write_bypass();
        test_x0();
        test_scoreboard();
        test_dual_write();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
